// File: rtl/q_argmax_sched_pkg.sv
// Shared constants and FSM state type for the Q-learning argmax scheduler.
// Used by q_argmax_sched, q_greater_cmp and the bench.
package q_pkg;

    localparam int Q_W   = 18;
    localparam int N_ACT = 9;
    localparam int ACT_W = 4;

    localparam logic [ACT_W-1:0] NO_ACTION = 4'hF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/q_argmax_sched_if.sv
// Agent/RAM-facing bundle of the argmax scheduler. The master side is the agent FSM
// together with the Q-table RAM; the slave side is q_argmax_sched.
interface q_argmax_sched_if #(
    parameter int Q_W    = 18,
    parameter int N_ACT  = 9,
    parameter int ADDR_W = 16
);
    // start is taken only while busy=0 (no queuing); busy stays high from the cycle after
    // accept through the done cycle; done is a single-cycle pulse and the result fields
    // hold until the next done. q_rd_data is valid RD_LAT cycles after q_rd_en.
    logic              start;
    logic [ADDR_W-1:0] q_base;
    logic [N_ACT-1:0]  avail_mask;
    logic              busy;
    logic              done;
    logic [3:0]        best_action;
    logic [Q_W-1:0]    best_q;
    logic              no_move;
    logic              q_rd_en;
    logic [ADDR_W-1:0] q_rd_addr;
    logic [Q_W-1:0]    q_rd_data;

    modport master (
        output start, q_base, avail_mask, q_rd_data,
        input  busy, done, best_action, best_q, no_move, q_rd_en, q_rd_addr
    );

    modport slave (
        input  start, q_base, avail_mask, q_rd_data,
        output busy, done, best_action, best_q, no_move, q_rd_en, q_rd_addr
    );

endinterface

// File: rtl/q_argmax_sched_greater_cmp.sv
// Shared "a strictly greater than b" comparator for the argmax scan.
// Signedness is selected here by macro SIGNED_Q_EN (signed when defined, unsigned otherwise).
module q_greater_cmp #(
    parameter int W = 18
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         gt
);

`ifdef SIGNED_Q_EN
    assign gt = $signed(a) > $signed(b);
`else
    assign gt = a > b;
`endif

endmodule

// File: rtl/q_argmax_sched.sv
// Serial argmax over the 9 action Q-values of one board state, one shared comparator.
// Comparator signedness follows macro SIGNED_Q_EN (see q_greater_cmp).
module q_argmax_sched
    import q_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int RD_LAT = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    q_argmax_sched_if.slave bus,
    output state_t          dbg_state
);

    state_t            state, state_nxt;
    logic [ACT_W-1:0]  cnt, cnt_nxt;
    logic [ADDR_W-1:0] base_r;
    logic [N_ACT-1:0]  mask_r;
    logic              accept, finish, issue_v, gt;

    logic [RD_LAT-1:0] tag_v;
    logic [ACT_W-1:0]  tag_idx [RD_LAT];

    logic              max_valid, max_valid_nxt;
    logic [Q_W-1:0]    max_q, max_q_nxt;
    logic [ACT_W-1:0]  max_idx, max_idx_nxt;

    logic [ACT_W-1:0]  res_action;
    logic [Q_W-1:0]    res_q;
    logic              res_no_move;

    assign accept  = (state == IDLE) && bus.start;
    assign issue_v = (state == ISSUE) && mask_r[cnt];

    q_greater_cmp #(.W(Q_W)) u_cmp (
        .a  (bus.q_rd_data),
        .b  (max_q),
        .gt (gt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // The drain phase reuses cnt to wait out the last RD_LAT tags.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = ISSUE;
                    cnt_nxt   = '0;
                end
            end
            ISSUE: begin
                if (cnt == ACT_W'(N_ACT - 1)) begin
                    state_nxt = DRAIN;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + ACT_W'(1);
                end
            end
            DRAIN: begin
                if (cnt == ACT_W'(RD_LAT - 1)) begin
                    state_nxt = DONE;
                    finish    = 1'b1;
                end else begin
                    cnt_nxt = cnt + ACT_W'(1);
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Strict greater-than plus in-order returns means ties keep the lower index.
    always_comb begin
        max_valid_nxt = max_valid;
        max_q_nxt     = max_q;
        max_idx_nxt   = max_idx;
        if (tag_v[RD_LAT-1] && (!max_valid || gt)) begin
            max_valid_nxt = 1'b1;
            max_q_nxt     = bus.q_rd_data;
            max_idx_nxt   = tag_idx[RD_LAT-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_v <= '0;
            for (int k = 0; k < RD_LAT; k++) tag_idx[k] <= '0;
        end else begin
            tag_v[0]   <= issue_v;
            tag_idx[0] <= cnt;
            for (int k = 1; k < RD_LAT; k++) begin
                tag_v[k]   <= tag_v[k-1];
                tag_idx[k] <= tag_idx[k-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_r      <= '0;
            mask_r      <= '0;
            max_valid   <= 1'b0;
            max_q       <= '0;
            max_idx     <= '0;
            res_action  <= NO_ACTION;
            res_q       <= '0;
            res_no_move <= 1'b0;
        end else begin
            if (accept) begin
                base_r    <= bus.q_base;
                mask_r    <= bus.avail_mask;
                max_valid <= 1'b0;
            end else begin
                max_valid <= max_valid_nxt;
                max_q     <= max_q_nxt;
                max_idx   <= max_idx_nxt;
            end
            // Results take the post-compare value so the final return is included.
            if (finish) begin
                res_action  <= max_valid_nxt ? max_idx_nxt : NO_ACTION;
                res_q       <= max_valid_nxt ? max_q_nxt : '0;
                res_no_move <= !max_valid_nxt;
            end
        end
    end

    assign bus.busy        = (state != IDLE);
    assign bus.done        = (state == DONE);
    assign bus.q_rd_en     = issue_v;
    assign bus.q_rd_addr   = (state == ISSUE) ? base_r + ADDR_W'(cnt) : '0;
    assign bus.best_action = res_action;
    assign bus.best_q      = res_q;
    assign bus.no_move     = res_no_move;
    assign dbg_state       = state;

endmodule

// File: tb/tb_q_argmax_sched.sv
// Self-checking bench for q_argmax_sched: directed table, randomized scans against a
// max-then-first-index reference model, and hand sequences for busy/reset/wrap corners.
`timescale 1ns/1ps
module tb_q_argmax_sched;
    import q_pkg::*;

    localparam int ADDR_W = 16;
    localparam int RES_W  = ACT_W + Q_W + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    q_argmax_sched_if #(.Q_W(Q_W), .N_ACT(N_ACT), .ADDR_W(ADDR_W)) bus ();
    q_argmax_sched_if #(.Q_W(Q_W), .N_ACT(N_ACT), .ADDR_W(ADDR_W)) bus2 ();
    state_t st1, st2;

    q_argmax_sched #(.ADDR_W(ADDR_W), .RD_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .dbg_state(st1)
    );
    q_argmax_sched #(.ADDR_W(ADDR_W), .RD_LAT(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2), .dbg_state(st2)
    );

    // Q-table model; unread cycles return random junk so masked data cannot sneak in.
    logic [Q_W-1:0] mem [0:65535];
    logic [Q_W-1:0] ram2_s1;
    always @(posedge clk) begin
        bus.q_rd_data  <= bus.q_rd_en ? mem[bus.q_rd_addr] : Q_W'($urandom);
        ram2_s1        <= bus2.q_rd_en ? mem[bus2.q_rd_addr] : Q_W'($urandom);
        bus2.q_rd_data <= ram2_s1;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: values of the scan under test.
    logic [Q_W-1:0] qv [N_ACT];

    function automatic longint key(input logic [Q_W-1:0] v);
`ifdef SIGNED_Q_EN
        return longint'($signed(v));
`else
        return longint'(v);
`endif
    endfunction

    function automatic logic [RES_W-1:0] model(input logic [N_ACT-1:0] m);
        longint mx = 0;
        bit any = 0;
        for (int i = 0; i < N_ACT; i++)
            if (m[i] && (!any || key(qv[i]) > mx)) begin mx = key(qv[i]); any = 1; end
        if (!any) return {NO_ACTION, Q_W'(0), 1'b1};
        for (int i = 0; i < N_ACT; i++)
            if (m[i] && key(qv[i]) == mx) return {ACT_W'(i), qv[i], 1'b0};
        return '0;
    endfunction

    // Scoreboard: every done pulse on bus pops one expected result.
    logic [RES_W-1:0] exp_q [$];
    logic [RES_W-1:0] exp_res;
    always @(negedge clk) begin
        if (bus.done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_res = exp_q.pop_front();
                check("best_action", 32'(bus.best_action), 32'(exp_res[RES_W-1 -: ACT_W]));
                check("best_q", 32'(bus.best_q), 32'(exp_res[Q_W:1]));
                check("no_move", 32'(bus.no_move), 32'(exp_res[0]));
            end
        end
    end

    task automatic load_mem(input logic [ADDR_W-1:0] base);
        for (int i = 0; i < N_ACT; i++) mem[base + ADDR_W'(i)] = qv[i];
    endtask

    // One scan on the RD_LAT=1 instance; poke=1 fires a second start with another mask at cycle 4.
    task automatic run_scan(input string tag, input logic [ADDR_W-1:0] base,
                            input logic [N_ACT-1:0] mask, input logic [RES_W-1:0] exp, input bit poke);
        int lat = 0;
        int addr_err = 0;
        int busy_err = 0;
        int post_err = 0;
        logic [N_ACT-1:0] en_seen = '0;
        load_mem(base);
        exp_q.push_back(exp);
        @(negedge clk);
        bus.start = 1'b1; bus.q_base = base; bus.avail_mask = mask;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.q_base = ADDR_W'($urandom); bus.avail_mask = N_ACT'($urandom);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (poke && k == 4) begin bus.start = 1'b1; bus.avail_mask = ~mask; end
            if (poke && k == 5) bus.start = 1'b0;
            if (!bus.busy) busy_err++;
            if (k <= N_ACT) begin
                en_seen[k-1] = bus.q_rd_en;
                if (bus.q_rd_en && bus.q_rd_addr !== base + ADDR_W'(k - 1)) addr_err++;
            end else if (bus.q_rd_en) begin
                addr_err++;
            end
            if (bus.done) begin lat = k; break; end
        end
        check({tag, "_latency"}, 32'(lat), 32'd11);
        check({tag, "_rd_en_pattern"}, 32'(en_seen), 32'(mask));
        check({tag, "_addr_errors"}, 32'(addr_err), 32'd0);
        check({tag, "_busy_errors"}, 32'(busy_err), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (bus.busy || bus.done || bus.best_q !== exp[Q_W:1]) post_err++;
        end
        check({tag, "_idle_hold_errors"}, 32'(post_err), 32'd0);
    endtask

    typedef struct {
        string                          name;
        logic [ADDR_W-1:0]              base;
        logic [N_ACT-1:0]               mask;
        logic [0:N_ACT-1][Q_W-1:0]      q;
        logic [ACT_W-1:0]               act;
        logic [Q_W-1:0]                 bq;
        logic                           nm;
    } vec_t;

    vec_t vecs [6];
    logic [0:N_ACT-1][Q_W-1:0] tp_q;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start = 1'b0; bus.q_base = '0; bus.avail_mask = '0;
        bus2.start = 1'b0; bus2.q_base = '0; bus2.avail_mask = '0;

        tp_q = {18'd10, 18'd20, 18'd5, 18'd300, 18'd7, 18'd300, 18'd1, 18'd0, 18'd299};
        vecs[0] = '{"unique_max", 16'h1000, 9'h1FF, tp_q, 4'd3, 18'd300, 1'b0};
        vecs[1] = '{"masked_max", 16'h2000, 9'h1F7, tp_q, 4'd5, 18'd300, 1'b0};
        vecs[2] = '{"no_move",    16'h3000, 9'h000, tp_q, 4'hF, 18'd0,   1'b1};
        vecs[3] = '{"wrap_lat1",  16'hFFFC, 9'h1FF, tp_q, 4'd3, 18'd300, 1'b0};
        vecs[4] = '{"all_equal",  16'h4000, 9'h1F0,
                    {18'd9, 18'd9, 18'd9, 18'd9, 18'd9, 18'd9, 18'd9, 18'd9, 18'd9},
                    4'd4, 18'd9, 1'b0};
`ifdef SIGNED_Q_EN
        vecs[5] = '{"neg_vs_pos", 16'h5000, 9'h003,
                    {18'h3FFFF, 18'h00001, 18'd50, 18'd50, 18'd50, 18'd50, 18'd50, 18'd50, 18'd50},
                    4'd1, 18'h00001, 1'b0};
`else
        vecs[5] = '{"neg_vs_pos", 16'h5000, 9'h003,
                    {18'h3FFFF, 18'h00001, 18'd50, 18'd50, 18'd50, 18'd50, 18'd50, 18'd50, 18'd50},
                    4'd0, 18'h3FFFF, 1'b0};
`endif

        // Reset state, in and out of reset.
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_best_action", 32'(bus.best_action), 32'hF);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_best_q", 32'(bus.best_q), 32'd0);
        check("rst_no_move", 32'(bus.no_move), 32'd0);
        check("rst_outputs_low", 32'({bus.done, bus.q_rd_en, bus2.busy, bus2.done}), 32'd0);
        check("rst_state", 32'(st1), 32'(IDLE));

        // Directed table.
        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < N_ACT; i++) qv[i] = vecs[t].q[i];
            run_scan(vecs[t].name, vecs[t].base, vecs[t].mask,
                     {vecs[t].act, vecs[t].bq, vecs[t].nm}, 1'b0);
        end

        // Randomized scans vs. the reference model; narrow value ranges provoke ties.
        for (int r = 0; r < 24; r++) begin
            logic [N_ACT-1:0] m;
            logic [ADDR_W-1:0] b;
            case (r % 4)
                0: m = '1;
                1: m = N_ACT'($urandom_range(0, 511));
                2: m = N_ACT'(1 << $urandom_range(0, N_ACT - 1));
                default: m = N_ACT'($urandom);
            endcase
            b = ADDR_W'($urandom);
            for (int i = 0; i < N_ACT; i++)
                qv[i] = (r % 2) ? Q_W'($urandom_range(0, 3)) : Q_W'($urandom);
            run_scan("random", b, m, model(m), 1'b0);
        end

        // Start while busy is ignored: one done, result from the first mask.
        for (int i = 0; i < N_ACT; i++) qv[i] = tp_q[i];
        run_scan("start_busy", 16'h6000, 9'h1F7, model(9'h1F7), 1'b1);

        // Reset mid-scan: immediate reset values, no done, then a clean scan.
        begin
            int dones = 0;
            load_mem(16'h7000);
            @(negedge clk);
            bus.start = 1'b1; bus.q_base = 16'h7000; bus.avail_mask = 9'h1FF;
            @(posedge clk); #1;
            bus.start = 1'b0;
            repeat (5) @(negedge clk);
            rst_n = 1'b0;
            #1;
            check("midrst_busy", 32'(bus.busy), 32'd0);
            check("midrst_best_action", 32'(bus.best_action), 32'hF);
            check("midrst_best_q_no_move_rd_en", 32'({bus.best_q, bus.no_move, bus.q_rd_en}), 32'd0);
            check("midrst_state", 32'(st1), 32'(IDLE));
            @(negedge clk);
            rst_n = 1'b1;
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                if (bus.done || bus.busy) dones++;
            end
            check("midrst_no_done", 32'(dones), 32'd0);
        end
        run_scan("after_reset", 16'h7000, 9'h1FF, model(9'h1FF), 1'b0);

        // Address wrap on the RD_LAT=2 instance.
        begin
            int lat = 0;
            int n_rd = 0;
            int addr_err = 0;
            logic [RES_W-1:0] e;
            for (int i = 0; i < N_ACT; i++) qv[i] = tp_q[i];
            load_mem(16'hFFFC);
            e = model(9'h1FF);
            @(negedge clk);
            bus2.start = 1'b1; bus2.q_base = 16'hFFFC; bus2.avail_mask = 9'h1FF;
            @(posedge clk); #1;
            bus2.start = 1'b0; bus2.avail_mask = '0;
            for (int k = 1; k <= 40; k++) begin
                @(negedge clk);
                if (bus2.q_rd_en) begin
                    if (bus2.q_rd_addr !== 16'hFFFC + ADDR_W'(n_rd)) addr_err++;
                    n_rd++;
                end
                if (bus2.done) begin
                    lat = k;
                    check("lat2_best_action", 32'(bus2.best_action), 32'(e[RES_W-1 -: ACT_W]));
                    check("lat2_best_q", 32'(bus2.best_q), 32'(e[Q_W:1]));
                    break;
                end
            end
            check("lat2_latency", 32'(lat), 32'd12);
            check("lat2_reads", 32'(n_rd), 32'd9);
            check("lat2_addr_errors", 32'(addr_err), 32'd0);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
